// File: rtl/vga_vram_ctrl.sv
// vga_vram_ctrl: arbitrates VGA pixel reads and host writes onto a single VRAM port.
// Defining VGA_VRAM_CLEAR_EN adds a post-reset sweep that zeroes the whole VRAM.
module vga_vram_ctrl #(
    parameter int PWIDTH      = 8,
    parameter int AWIDTH      = 20,
    parameter int LATENCY     = 4,
    parameter int WR_WAIT_MAX = 16
) (
    input  logic              clk_core,
    input  logic              rst_core,
    input  logic              vram_rd,
    input  logic [AWIDTH-1:0] vram_addr,
    output logic              vram_busy,
    output logic [PWIDTH-1:0] vram_data,
    output logic              vram_vld,
    input  logic              host_wr,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [PWIDTH-1:0] host_wdata,
    output logic              host_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [PWIDTH-1:0] mem_wdata,
    input  logic [PWIDTH-1:0] mem_rdata
);

    localparam int WCW = $clog2(WR_WAIT_MAX) + 1;

`ifdef VGA_VRAM_CLEAR_EN
    typedef enum logic [1:0] {READ, WRITE, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
    logic [AWIDTH-1:0] clr_addr;
`else
    typedef enum logic {READ, WRITE} state_t;
    localparam state_t RESET_STATE = READ;
`endif

    state_t             state;
    logic [LATENCY-1:0] vld_sr;
    logic [WCW-1:0]     wait_cnt;
    logic               rd_accept;
    logic               wr_go;

    assign rd_accept  = (state == READ) && vram_rd;
    // A pending write steals the port on an idle read cycle, or forcibly once it has waited long enough
    assign wr_go      = (state == READ) && host_wr &&
                        (!vram_rd || (wait_cnt == WCW'(WR_WAIT_MAX - 1)));
    assign vram_busy  = (state != READ);
    assign host_ready = (state == WRITE);
    assign vram_vld   = vld_sr[LATENCY-1];
    assign vram_data  = mem_rdata;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state    <= RESET_STATE;
            vld_sr   <= '0;
            wait_cnt <= '0;
`ifdef VGA_VRAM_CLEAR_EN
            clr_addr <= '0;
`endif
        end else begin
            vld_sr <= (vld_sr << 1) | LATENCY'(rd_accept);

            if ((state == READ) && host_wr)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            case (state)
                READ:    if (wr_go) state <= WRITE;
                WRITE:   state <= READ;
`ifdef VGA_VRAM_CLEAR_EN
                CLEAR: begin
                    if (clr_addr == '1) begin
                        state    <= READ;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
`endif
                default: state <= READ;
            endcase
        end
    end

    // Memory strobes are held low while reset is asserted, whatever the state register holds
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = vram_addr;
        mem_wdata = '0;
        if (!rst_core) begin
            case (state)
                READ:    mem_en = vram_rd;
                WRITE: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = host_addr;
                    mem_wdata = host_wdata;
                end
`ifdef VGA_VRAM_CLEAR_EN
                CLEAR: begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = clr_addr;
                end
`endif
                default: mem_en = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/vga_vram_ctrl.md
VGA_VRAM_CTRL -- requirements
Module: vga_vram_ctrl

Interface
REQ-001 SHALL have parameter PWIDTH, default 8, pixel/data width.
REQ-002 SHALL have parameter AWIDTH, default 20, VRAM address width ({v_addr,h_addr}).
REQ-003 SHALL have parameter LATENCY, default 4, memory read latency in cycles (1..15).
REQ-004 SHALL have parameter WR_WAIT_MAX, default 16, maximum cycles a pending host write waits.
REQ-005 SHALL have ports: clk_core in 1, core clock; rst_core in 1, reset. One clock; reset is asynchronous and active-high.
REQ-006 SHALL have read-port ports: vram_rd in 1 read request; vram_addr in AWIDTH read address; vram_busy out 1 read port blocked; vram_data out PWIDTH read data; vram_vld out 1 read data valid.
REQ-007 SHALL have host ports: host_wr in 1 write request (held until accepted); host_addr in AWIDTH; host_wdata in PWIDTH; host_ready out 1 write accepted pulse.
REQ-008 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out AWIDTH; mem_wdata out PWIDTH; mem_rdata in PWIDTH (valid LATENCY cycles after a read enable).

Function
REQ-009 SHALL implement FSM states READ, WRITE, CLEAR; vram_busy = (state != READ), decoded from the state register only.
REQ-010 SHALL, in READ with vram_rd=1, issue mem_en=1, mem_we=0, mem_addr=vram_addr in the same cycle (combinational).
REQ-011 SHALL ignore vram_rd while vram_busy=1 (no memory access, no vram_vld generated).
REQ-012 SHALL assert vram_vld exactly LATENCY cycles after each accepted read, one cycle per read, via a LATENCY-deep valid shift register; vram_data = mem_rdata.
REQ-013 SHALL sustain back-to-back reads at one per cycle with no bubbles.
REQ-014 SHALL keep a wait counter (width $clog2(WR_WAIT_MAX)+1) incrementing each READ cycle with host_wr=1, clearing when state is WRITE or host_wr=0.
REQ-015 SHALL go READ->WRITE next cycle when host_wr=1 and (vram_rd=0 or wait counter == WR_WAIT_MAX-1); the read in that same cycle, if any, is still accepted.
REQ-016 SHALL, in WRITE, drive mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata, host_ready=1 for exactly one cycle, then return to READ.
REQ-017 SHALL not disturb in-flight reads during WRITE/CLEAR; their vram_vld still fires on schedule.
REQ-018 SHALL keep host_ready=0 outside WRITE; at most one write per WRITE visit; consecutive host writes separated by at least one READ cycle.
REQ-019 SHALL drive mem_en=0, mem_we=0 when no access occurs; mem_addr/mem_wdata are don't-care then.

Reset
REQ-020 SHALL asynchronously clear on rst_core=1: valid shift register, wait counter, clear address; vram_vld=0, host_ready=0, mem_en=0, mem_we=0.
REQ-021 SHALL reset state to CLEAR (vram_busy=1) when VGA_VRAM_CLEAR_EN is defined, else READ (vram_busy=0).
REQ-022 SHALL, on reset asserted mid-operation, discard pending reads (no vram_vld after release) and abort any clear sweep, restarting it from address 0.

Configuration
REQ-023 SHALL, with VGA_VRAM_CLEAR_EN defined, in CLEAR write 0 to addresses 0..2**AWIDTH-1, one per cycle (mem_en=1, mem_we=1), host_ready=0, reads ignored, then enter READ the cycle after the last address.
REQ-024 SHALL, without VGA_VRAM_CLEAR_EN, omit CLEAR state and clear-address counter entirely.

Verification
REQ-025 Reset release, macro off; vram_rd=1 at addr 0..9 for 10 cycles -> vram_vld high cycles 4..13 after first read, data matches memory model.
REQ-026 host_wr=1 addr 0x00123 data 0xA5, vram_rd=0 -> host_ready next cycle, mem_we=1 addr 0x00123 data 0xA5, vram_busy=1 one cycle.
REQ-027 Continuous vram_rd=1 plus host_wr=1 -> host_ready exactly 16 cycles after host_wr rises; exactly one read dropped cycle; earlier reads' vram_vld unaffected.
REQ-028 vram_rd=1 during WRITE cycle -> no mem_en read, no extra vram_vld.
REQ-029 Macro on, AWIDTH=4: after reset 16 zero writes at addr 0..15, vram_busy=1 for 16 cycles, then 0; reset at clear addr 7 -> sweep restarts at 0.
